// File: rtl/fpaddsub_norm_pipe_pkg.sv
// Shared FP_AddSub widths, pipeline stage structs and helpers for the post-add normalizer.
// The width macros can be overridden on the command line; the localparams derive from them.
`ifndef MANTISSA
`define MANTISSA 10
`endif
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef DWIDTH
`define DWIDTH (`MANTISSA+6)
`endif

package fpaddsub_norm_pipe_pkg;

    localparam int MANT_W = `MANTISSA;
    localparam int EXP_W  = `EXPONENT;
    localparam int DWIDTH = `DWIDTH;
    // One extra bit so the counter can return DWIDTH for an all-zero input.
    localparam int LZC_W  = $clog2(`DWIDTH) + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic [DWIDTH:0]   sum;
        logic              sgn;
        logic              opr;
        logic [EXP_W-1:0]  emax;
        logic [LZC_W-1:0]  lzc;
    } s1_t;

    typedef struct packed {
        logic [DWIDTH-1:0] m;
        logic [EXP_W-1:0]  e;
        logic              sgn;
        logic              zero;
        logic              ovf;
        logic              uflow;
`ifdef FPADDSUB_NORM_STICKY_EN
        logic              sticky;
`endif
    } norm_t;

    function automatic logic lzc_ge_emax(input logic [LZC_W-1:0] lzc,
                                         input logic [EXP_W-1:0] emax);
        return int'(lzc) >= int'(emax);
    endfunction

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational leading-zero counter over DWIDTH bits; returns DWIDTH for an all-zero input.
// No latency, no flow control.
module fpaddsub_lzc
    import fpaddsub_norm_pipe_pkg::*;
(
    input  logic [DWIDTH-1:0] i_dat,
    output logic [LZC_W-1:0]  o_cnt
);

    // Scanning upward lets the highest set bit write last and win.
    always_comb begin
        o_cnt = LZC_W'(DWIDTH);
        for (int i = 0; i < DWIDTH; i++) begin
            if (i_dat[i]) o_cnt = LZC_W'(DWIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpaddsub_norm_pipe.sv
// Two-stage FP add/sub normalizer, 2-cycle latency, 1 beat/cycle; valid/ready backpressure stalls both stages.
// Optional Sticky output enabled by defining FPADDSUB_NORM_STICKY_EN.
module fpaddsub_norm_pipe
    import fpaddsub_norm_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH:0]   Sum,
    input  logic              PSgn,
    input  logic              Opr,
    input  logic [EXP_W-1:0]  Emax,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] NormM,
    output logic [EXP_W-1:0]  NormE,
    output logic              NSgn,
    output logic              Zero,
    output logic              Ovf,
    output logic              Uflow
`ifdef FPADDSUB_NORM_STICKY_EN
    ,
    output logic              Sticky
`endif
);

    logic             r_s1_vld;
    s1_t              r_s1;
    logic             r_s2_vld;
    norm_t            r_s2;

    logic             w_s1_adv;
    logic             w_in_acc;
    logic [LZC_W-1:0] w_lzc;
    s1_t              w_s1_nxt;
    norm_t            w_s2_nxt;
    logic [DWIDTH-1:0] w_low;

    assign w_s1_adv = !r_s2_vld || out_ready;
    assign in_ready = !r_s1_vld || w_s1_adv;
    assign w_in_acc = in_valid && in_ready;

    fpaddsub_lzc u_lzc (
        .i_dat (Sum[DWIDTH-1:0]),
        .o_cnt (w_lzc)
    );

    always_comb begin
        w_s1_nxt      = '0;
        w_s1_nxt.sum  = Sum;
        w_s1_nxt.sgn  = PSgn;
        w_s1_nxt.opr  = Opr;
        w_s1_nxt.emax = Emax;
        w_s1_nxt.lzc  = w_lzc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            if (in_ready) r_s1_vld <= in_valid;
            if (w_in_acc) r_s1     <= w_s1_nxt;
        end
    end

    assign w_low = r_s1.sum[DWIDTH-1:0];

    // Priority: exact zero, carry-out right shift, underflow clamp, normal left shift.
    always_comb begin
        w_s2_nxt     = '0;
        w_s2_nxt.sgn = r_s1.sgn;
        if (r_s1.sum == '0) begin
            w_s2_nxt.zero = 1'b1;
            w_s2_nxt.sgn  = r_s1.opr ? 1'b0 : r_s1.sgn;
        end else if (r_s1.sum[DWIDTH]) begin
            w_s2_nxt.m = r_s1.sum[DWIDTH:1];
            if (r_s1.emax >= EXP_SAT) begin
                w_s2_nxt.e   = EXP_MAX;
                w_s2_nxt.ovf = 1'b1;
            end else begin
                w_s2_nxt.e = r_s1.emax + EXP_W'(1);
            end
`ifdef FPADDSUB_NORM_STICKY_EN
            w_s2_nxt.sticky = r_s1.sum[0];
`endif
        end else if (lzc_ge_emax(r_s1.lzc, r_s1.emax)) begin
            w_s2_nxt.m     = w_low << r_s1.emax;
            w_s2_nxt.e     = '0;
            w_s2_nxt.uflow = 1'b1;
        end else begin
            // lzc < emax here, so the narrowing cast cannot lose bits.
            w_s2_nxt.m = w_low << r_s1.lzc;
            w_s2_nxt.e = r_s1.emax - EXP_W'(r_s1.lzc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_vld <= 1'b0;
            r_s2     <= '0;
        end else if (w_s1_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) r_s2 <= w_s2_nxt;
        end
    end

    assign out_valid = r_s2_vld;
    assign NormM     = r_s2.m;
    assign NormE     = r_s2.e;
    assign NSgn      = r_s2.sgn;
    assign Zero      = r_s2.zero;
    assign Ovf       = r_s2.ovf;
    assign Uflow     = r_s2.uflow;
`ifdef FPADDSUB_NORM_STICKY_EN
    assign Sticky    = r_s2.sticky;
`endif

endmodule

// File: tb/tb_fpaddsub_norm_pipe.sv
// Directed self-checking bench for fpaddsub_norm_pipe (default 16-bit datapath, 5-bit exponent).
module tb_fpaddsub_norm_pipe;
    import fpaddsub_norm_pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DWIDTH:0]   Sum = '0;
    logic              PSgn = 1'b0;
    logic              Opr = 1'b0;
    logic [EXP_W-1:0]  Emax = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DWIDTH-1:0] NormM;
    logic [EXP_W-1:0]  NormE;
    logic              NSgn, Zero, Ovf, Uflow;
`ifdef FPADDSUB_NORM_STICKY_EN
    logic              Sticky;
`endif

    int total = 0;
    int bad   = 0;

    fpaddsub_norm_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sum       (Sum),
        .PSgn      (PSgn),
        .Opr       (Opr),
        .Emax      (Emax),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .NormM     (NormM),
        .NormE     (NormE),
        .NSgn      (NSgn),
        .Zero      (Zero),
        .Ovf       (Ovf),
        .Uflow     (Uflow)
`ifdef FPADDSUB_NORM_STICKY_EN
        ,
        .Sticky    (Sticky)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic [DWIDTH:0] s, input logic ps, input logic op,
                           input logic [EXP_W-1:0] em,
                           input logic [DWIDTH-1:0] xm, input logic [EXP_W-1:0] xe,
                           input logic xs, input logic xz, input logic xo, input logic xu,
                           input logic xst);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Sum = s; PSgn = ps; Opr = op; Emax = em;
        #1 chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".NormM"}, 32'(NormM), 32'(xm));
        chk({tag, ".NormE"}, 32'(NormE), 32'(xe));
        chk({tag, ".NSgn"},  32'(NSgn),  32'(xs));
        chk({tag, ".Zero"},  32'(Zero),  32'(xz));
        chk({tag, ".Ovf"},   32'(Ovf),   32'(xo));
        chk({tag, ".Uflow"}, 32'(Uflow), 32'(xu));
`ifdef FPADDSUB_NORM_STICKY_EN
        chk({tag, ".Sticky"}, 32'(Sticky), 32'(xst));
`else
        if (xst) total += 0;
`endif
    endtask

    initial begin
        logic [DWIDTH:0]   st_sum [5];
        logic [DWIDTH-1:0] st_m   [5];
        logic [DWIDTH-1:0] held_m;
        logic              held;
        int                tx, rx;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.NormM", 32'(NormM), 32'd0);
        chk("rst.NormE", 32'(NormE), 32'd0);
        chk("rst.flags", 32'({NSgn, Zero, Ovf, Uflow}), 32'd0);
        rst = 1'b1;
        #1 chk("rst.in_ready", 32'(in_ready), 32'd1);

        //        tag            Sum         PSgn  Opr   Emax     NormM      NormE    NSgn  Zero  Ovf   Uflow Sticky
        run_vec("carry",        17'h10000, 1'b0, 1'b0, 5'd15, 16'h8000, 5'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("norm",         17'h00040, 1'b0, 1'b0, 5'd15, 16'h8000, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("uflow",        17'h00040, 1'b0, 1'b0, 5'd3,  16'h0200, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vec("zero_sub",     17'h00000, 1'b1, 1'b1, 5'd15, 16'h0000, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("ovf30",        17'h10000, 1'b0, 1'b0, 5'd30, 16'h8000, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("carry_sticky", 17'h1FFFF, 1'b1, 1'b0, 5'd10, 16'hFFFF, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec("zero_add",     17'h00000, 1'b1, 1'b0, 5'd7,  16'h0000, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_vec("lzc0",         17'h08001, 1'b0, 1'b1, 5'd5,  16'h8001, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("lzc_eq_emax",  17'h00040, 1'b0, 1'b0, 5'd9,  16'h8000, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_vec("lzc_lt_emax",  17'h00040, 1'b1, 1'b0, 5'd10, 16'h8000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("ovf31",        17'h10002, 1'b0, 1'b0, 5'd31, 16'h8001, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_vec("lsb_only",     17'h00001, 1'b0, 1'b0, 5'd20, 16'h8000, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec("emax0",        17'h00100, 1'b0, 1'b0, 5'd0,  16'h0100, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Five back-to-back beats with out_ready low on cycles 2-5
        st_sum = '{17'h10000, 17'h10002, 17'h10004, 17'h10006, 17'h10008};
        st_m   = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8004};
        tx = 0; rx = 0; held = 1'b0; held_m = '0;
        for (int c = 1; c <= 40 && rx < 5; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (tx < 5);
            if (tx < 5) begin
                Sum = st_sum[tx]; Emax = 5'd15; PSgn = 1'b0; Opr = 1'b0;
            end
            #1;
            if (held) begin
                chk("stall.hold_valid", 32'(out_valid), 32'd1);
                chk("stall.hold_NormM", 32'(NormM), 32'(held_m));
            end
            if (c == 3) begin
                chk("stall.in_ready_low", 32'(in_ready), 32'd0);
                chk("stall.beats_held", 32'(tx), 32'd2);
            end
            held   = out_valid && !out_ready;
            held_m = NormM;
            if (out_valid && out_ready) begin
                chk("stall.NormM", 32'(NormM), 32'(st_m[rx]));
                chk("stall.NormE", 32'(NormE), 32'd16);
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        chk("stall.rx_count", 32'(rx), 32'd5);
        chk("stall.tx_count", 32'(tx), 32'd5);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        Sum = 17'h10000; Emax = 5'd15; PSgn = 1'b0; Opr = 1'b0;
        @(negedge clk);
        Sum = 17'h00040;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst.pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.NormM", 32'(NormM), 32'd0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        Sum = 17'h00040; Emax = 5'd3; PSgn = 1'b0; Opr = 1'b0;
        #1 chk("midrst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst.edge1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("midrst.edge2_valid", 32'(out_valid), 32'd1);
        chk("midrst.NormM", 32'(NormM), 32'h0200);
        chk("midrst.Uflow", 32'(Uflow), 32'd1);
        @(negedge clk);
        chk("midrst.drained", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
